decode_stage: RTL and testbench

- Instruction-decode stage of the multi-cycle MIPS core; sits directly downstream of the fetch stage.
- Captures the {pc, inst} bus when fetch signals completion and reads operands from the register file.
- Resolves branches and jumps, returning {taken, target} to fetch, and hands a packed control/operand bus to execute with a one-cycle done pulse.

---
 rtl/decode_stage_pkg.sv | 56 +++++
 rtl/decode_stage_id_decoder.sv | 110 +++++++++++
 rtl/decode_stage.sv | 130 +++++++++++++
 tb/tb_decode_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared constants and types for the MIPS decode stage: opcodes, funct codes,
// alu_op one-hot bit positions, mem_ctrl bits and bus widths.
package decode_stage_pkg;

    localparam int unsigned IfIdW  = 64;
    localparam int unsigned IdExeW = 149;
    localparam int unsigned JbrW   = 33;
    localparam int unsigned AluOpW = 12;

    localparam logic [5:0] OpSpecial = 6'h00;
    localparam logic [5:0] OpJ       = 6'h02;
    localparam logic [5:0] OpJal     = 6'h03;
    localparam logic [5:0] OpBeq     = 6'h04;
    localparam logic [5:0] OpBne     = 6'h05;
    localparam logic [5:0] OpAddiu   = 6'h09;
    localparam logic [5:0] OpSlti    = 6'h0a;
    localparam logic [5:0] OpAndi    = 6'h0c;
    localparam logic [5:0] OpOri     = 6'h0d;
    localparam logic [5:0] OpLui     = 6'h0f;
    localparam logic [5:0] OpLw      = 6'h23;
    localparam logic [5:0] OpSw      = 6'h2b;

    localparam logic [5:0] FnSll  = 6'h00;
    localparam logic [5:0] FnSrl  = 6'h02;
    localparam logic [5:0] FnJr   = 6'h08;
    localparam logic [5:0] FnAddu = 6'h21;
    localparam logic [5:0] FnSubu = 6'h23;
    localparam logic [5:0] FnAnd  = 6'h24;
    localparam logic [5:0] FnOr   = 6'h25;
    localparam logic [5:0] FnXor  = 6'h26;
    localparam logic [5:0] FnNor  = 6'h27;
    localparam logic [5:0] FnSlt  = 6'h2a;

    // alu_op is one-hot, ADD in the MSB; bits 1:0 are reserved
    localparam int unsigned AluAdd = 11;
    localparam int unsigned AluSub = 10;
    localparam int unsigned AluSlt = 9;
    localparam int unsigned AluAnd = 8;
    localparam int unsigned AluNor = 7;
    localparam int unsigned AluOr  = 6;
    localparam int unsigned AluXor = 5;
    localparam int unsigned AluSll = 4;
    localparam int unsigned AluSrl = 3;
    localparam int unsigned AluLui = 2;

    localparam int unsigned MemLd = 3;
    localparam int unsigned MemSt = 2;

    typedef enum logic [2:0] {JbrNone, JbrBeq, JbrBne, JbrJ, JbrJr} jbr_type_e;
    typedef enum logic [1:0] {StIdle, StRead, StDone} state_e;

    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/decode_stage_id_decoder.sv
// Combinational instruction decoder: maps instruction fields to ALU control,
// extended immediate, operand selects, destination, memory control and jump type.
module decode_stage_id_decoder
    import decode_stage_pkg::*;
#(
    parameter logic [4:0] LINK_REG = 5'd31
) (
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    output logic [AluOpW-1:0] alu_op,
    output logic [31:0]       imm_ext,
    output logic              use_imm,
    output logic              use_sa,
    output logic              use_link,
    output logic [4:0]        wdest,
    output logic [3:0]        mem_ctrl,
    output jbr_type_e         jbr_type
);

    always_comb begin
        alu_op   = '0;
        imm_ext  = sign_ext16(imm);
        use_imm  = 1'b0;
        use_sa   = 1'b0;
        use_link = 1'b0;
        wdest    = '0;
        mem_ctrl = '0;
        jbr_type = JbrNone;
        case (opcode)
            OpSpecial: begin
                wdest = rd;
                case (funct)
                    FnAddu: alu_op[AluAdd] = 1'b1;
                    FnSubu: alu_op[AluSub] = 1'b1;
                    FnAnd:  alu_op[AluAnd] = 1'b1;
                    FnOr:   alu_op[AluOr]  = 1'b1;
                    FnXor:  alu_op[AluXor] = 1'b1;
                    FnNor:  alu_op[AluNor] = 1'b1;
                    FnSlt:  alu_op[AluSlt] = 1'b1;
                    FnSll: begin
                        alu_op[AluSll] = 1'b1;
                        use_sa         = 1'b1;
                    end
                    FnSrl: begin
                        alu_op[AluSrl] = 1'b1;
                        use_sa         = 1'b1;
                    end
                    FnJr: begin
                        wdest    = '0;
                        jbr_type = JbrJr;
                    end
                    default: wdest = '0;
                endcase
            end
            OpAddiu: begin
                alu_op[AluAdd] = 1'b1;
                use_imm        = 1'b1;
                wdest          = rt;
            end
            OpSlti: begin
                alu_op[AluSlt] = 1'b1;
                use_imm        = 1'b1;
                wdest          = rt;
            end
            OpAndi: begin
                alu_op[AluAnd] = 1'b1;
                imm_ext        = {16'h0, imm};
                use_imm        = 1'b1;
                wdest          = rt;
            end
            OpOri: begin
                alu_op[AluOr] = 1'b1;
                imm_ext       = {16'h0, imm};
                use_imm       = 1'b1;
                wdest         = rt;
            end
            OpLui: begin
                alu_op[AluLui] = 1'b1;
                imm_ext        = {imm, 16'h0};
                use_imm        = 1'b1;
                wdest          = rt;
            end
            OpLw: begin
                alu_op[AluAdd]  = 1'b1;
                use_imm         = 1'b1;
                wdest           = rt;
                mem_ctrl[MemLd] = 1'b1;
            end
            OpSw: begin
                alu_op[AluAdd]  = 1'b1;
                use_imm         = 1'b1;
                mem_ctrl[MemSt] = 1'b1;
            end
            OpBeq: jbr_type = JbrBeq;
            OpBne: jbr_type = JbrBne;
            OpJ:   jbr_type = JbrJ;
            OpJal: begin
                jbr_type       = JbrJ;
                use_link       = 1'b1;
                alu_op[AluAdd] = 1'b1;
                wdest          = LINK_REG;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Multi-cycle MIPS decode stage: captures fetch output, reads operands, resolves
// branches/jumps back to fetch and hands a packed control/operand bus to execute.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter logic [4:0]  LINK_REG = 5'd31,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IF_over,
    input  logic [IfIdW-1:0]  IF_ID_bus,
    input  logic              ID_allow,
    input  logic [31:0]       rs_value,
    input  logic [31:0]       rt_value,
    output logic [4:0]        rs_addr,
    output logic [4:0]        rt_addr,
    output logic [JbrW-1:0]   jbr_bus,
    output logic              ID_over,
    output logic [IdExeW-1:0] ID_EXE_bus,
    output logic [31:0]       ID_pc,
    output logic [31:0]       ID_inst
);

    state_e              state_q, state_d;
    logic [31:0]         pc_q, inst_q;
    logic [JbrW-1:0]     jbr_q, jbr_d;
    logic [IdExeW-1:0]   ex_q, ex_d;
    logic                capture, load_out;

    logic [AluOpW-1:0]   alu_op;
    logic [31:0]         imm_ext;
    logic                use_imm, use_sa, use_link;
    logic [4:0]          wdest;
    logic [3:0]          mem_ctrl;
    jbr_type_e           jbr_type;

    logic [31:0]         pc4, br_target, alu_src1, alu_src2;

    decode_stage_id_decoder #(
        .LINK_REG (LINK_REG)
    ) u_id_decoder (
        .opcode   (inst_q[31:26]),
        .funct    (inst_q[5:0]),
        .rt       (inst_q[20:16]),
        .rd       (inst_q[15:11]),
        .imm      (inst_q[15:0]),
        .alu_op   (alu_op),
        .imm_ext  (imm_ext),
        .use_imm  (use_imm),
        .use_sa   (use_sa),
        .use_link (use_link),
        .wdest    (wdest),
        .mem_ctrl (mem_ctrl),
        .jbr_type (jbr_type)
    );

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        load_out = 1'b0;
        ID_over  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (IF_over) begin
                    capture = 1'b1;
                    state_d = StRead;
                end
            end
            StRead: begin
                load_out = 1'b1;
                state_d  = StDone;
            end
            StDone: begin
                if (ID_allow) begin
                    ID_over = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign pc4       = pc_q + 32'd4;
    assign br_target = pc4 + {imm_ext[29:0], 2'b00};
    assign alu_src1  = use_link ? pc4 : (use_sa ? {27'd0, inst_q[10:6]} : rs_value);
    assign alu_src2  = use_link ? 32'd0 : (use_imm ? imm_ext : rt_value);
    assign ex_d      = {alu_op, alu_src1, alu_src2, mem_ctrl, rt_value, wdest, pc_q};

    // Target is only meaningful when taken; a not-taken result leaves the whole bus zero.
    always_comb begin
        jbr_d = '0;
        case (jbr_type)
            JbrBeq:  if (rs_value == rt_value) jbr_d = {1'b1, br_target};
            JbrBne:  if (rs_value != rt_value) jbr_d = {1'b1, br_target};
            JbrJ:    jbr_d = {1'b1, pc4[31:28], inst_q[25:0], 2'b00};
            JbrJr:   jbr_d = {1'b1, rs_value};
            default: jbr_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            jbr_q   <= '0;
            ex_q    <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                pc_q   <= IF_ID_bus[63:32];
                inst_q <= IF_ID_bus[31:0];
                jbr_q  <= '0;
            end
            if (load_out) begin
                jbr_q <= jbr_d;
                ex_q  <= ex_d;
            end
        end
    end

    assign rs_addr    = inst_q[25:21];
    assign rt_addr    = inst_q[20:16];
    assign jbr_bus    = jbr_q;
    assign ID_EXE_bus = ex_q;
    assign ID_pc      = pc_q;
    assign ID_inst    = inst_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-computed vectors covering ALU, branch,
// jump, stall, ignored-capture, mid-instruction reset and illegal-opcode cases.
module tb_decode_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         IF_over;
    logic [63:0]  IF_ID_bus;
    logic         ID_allow;
    logic [31:0]  rs_value, rt_value;
    logic [4:0]   rs_addr, rt_addr;
    logic [32:0]  jbr_bus;
    logic         ID_over;
    logic [148:0] ID_EXE_bus;
    logic [31:0]  ID_pc, ID_inst;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [11:0] OpAdd = 12'h800;
    localparam logic [11:0] OpAnd = 12'h100;
    localparam logic [11:0] OpSll = 12'h010;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk        (clk),
        .reset      (reset),
        .IF_over    (IF_over),
        .IF_ID_bus  (IF_ID_bus),
        .ID_allow   (ID_allow),
        .rs_value   (rs_value),
        .rt_value   (rt_value),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .jbr_bus    (jbr_bus),
        .ID_over    (ID_over),
        .ID_EXE_bus (ID_EXE_bus),
        .ID_pc      (ID_pc),
        .ID_inst    (ID_inst)
    );

    task automatic check_eq(input string tag, input logic [148:0] got, input logic [148:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Capture at the first edge, READ cycle checks, returns at the negedge inside DONE.
    task automatic send(input logic [31:0] pc, input logic [31:0] inst,
                        input logic [31:0] rs, input logic [31:0] rt);
        @(negedge clk);
        IF_over   = 1'b1;
        IF_ID_bus = {pc, inst};
        rs_value  = rs;
        rt_value  = rt;
        @(negedge clk);
        IF_over = 1'b0;
        check_eq("read_no_over", 149'(ID_over), 149'(0));
        check_eq("rs_addr", 149'(rs_addr), 149'(inst[25:21]));
        check_eq("rt_addr", 149'(rt_addr), 149'(inst[20:16]));
        check_eq("jbr_clear_on_capture", 149'(jbr_bus), 149'(0));
        @(negedge clk);
    endtask

    task automatic pulse_check(input string tag);
        check_eq({tag, "_over"}, 149'(ID_over), 149'(1));
        @(negedge clk);
        check_eq({tag, "_over_end"}, 149'(ID_over), 149'(0));
    endtask

    initial begin
        logic [148:0] exp_bus;
        reset     = 1'b1;
        IF_over   = 1'b0;
        IF_ID_bus = '0;
        ID_allow  = 1'b1;
        rs_value  = '0;
        rt_value  = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_jbr", 149'(jbr_bus), 149'(0));
        check_eq("rst_over", 149'(ID_over), 149'(0));
        check_eq("rst_exe", ID_EXE_bus, 149'(0));
        check_eq("rst_pc", 149'(ID_pc), 149'(0));
        check_eq("rst_inst", 149'(ID_inst), 149'(0));
        reset = 1'b0;

        // ADDIU $2, $1, 5
        send(32'h100, 32'h24220005, 32'd7, 32'd99);
        check_eq("addiu_aluop", 149'(ID_EXE_bus[148:137]), 149'(OpAdd));
        check_eq("addiu_src1", 149'(ID_EXE_bus[136:105]), 149'(7));
        check_eq("addiu_src2", 149'(ID_EXE_bus[104:73]), 149'(5));
        check_eq("addiu_wdest", 149'(ID_EXE_bus[36:32]), 149'(2));
        check_eq("addiu_pc", 149'(ID_EXE_bus[31:0]), 149'(32'h100));
        check_eq("addiu_mem", 149'(ID_EXE_bus[72:69]), 149'(0));
        check_eq("addiu_jbr", 149'(jbr_bus), 149'(0));
        pulse_check("addiu");

        // BEQ $1, $2, -1 taken: target = 0x204 - 4
        send(32'h200, 32'h1022FFFF, 32'd3, 32'd3);
        check_eq("beq_t_jbr", 149'(jbr_bus), 149'(33'h1_0000_0200));
        check_eq("beq_t_wdest", 149'(ID_EXE_bus[36:32]), 149'(0));
        pulse_check("beq_t");
        check_eq("jbr_held_idle", 149'(jbr_bus), 149'(33'h1_0000_0200));

        send(32'h200, 32'h1022FFFF, 32'd3, 32'd4);
        check_eq("beq_nt_jbr", 149'(jbr_bus), 149'(0));
        pulse_check("beq_nt");

        // JAL index 0x40 across a 256MB region boundary
        send(32'h0FFFFFFC, 32'h0C000040, 32'd0, 32'd0);
        check_eq("jal_jbr", 149'(jbr_bus), 149'(33'h1_1000_0100));
        check_eq("jal_wdest", 149'(ID_EXE_bus[36:32]), 149'(31));
        check_eq("jal_src1", 149'(ID_EXE_bus[136:105]), 149'(32'h10000000));
        check_eq("jal_src2", 149'(ID_EXE_bus[104:73]), 149'(0));
        check_eq("jal_aluop", 149'(ID_EXE_bus[148:137]), 149'(OpAdd));
        pulse_check("jal");

        // SLL $4, $2, 3
        send(32'h104, 32'h000220C0, 32'd0, 32'h0000_00F0);
        check_eq("sll_aluop", 149'(ID_EXE_bus[148:137]), 149'(OpSll));
        check_eq("sll_src1", 149'(ID_EXE_bus[136:105]), 149'(3));
        check_eq("sll_src2", 149'(ID_EXE_bus[104:73]), 149'(32'hF0));
        check_eq("sll_wdest", 149'(ID_EXE_bus[36:32]), 149'(4));
        pulse_check("sll");

        // ANDI $5, $1, 0x8000 zero-extends
        send(32'h108, 32'h30258000, 32'h1234, 32'd0);
        check_eq("andi_aluop", 149'(ID_EXE_bus[148:137]), 149'(OpAnd));
        check_eq("andi_src2", 149'(ID_EXE_bus[104:73]), 149'(32'h0000_8000));
        check_eq("andi_wdest", 149'(ID_EXE_bus[36:32]), 149'(5));
        pulse_check("andi");

        // SW $2, 8($1) with execute stalled for 5 cycles
        ID_allow = 1'b0;
        send(32'h400, 32'hAC220008, 32'h1000, 32'hDEAD);
        exp_bus = {OpAdd, 32'h1000, 32'h8, 4'b0100, 32'hDEAD, 5'd0, 32'h400};
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_over", 149'(ID_over), 149'(0));
            check_eq("stall_bus", ID_EXE_bus, exp_bus);
            if (i == 1) begin
                rs_value = 32'd5;
                rt_value = 32'd6;
            end
            IF_over   = (i == 2);
            IF_ID_bus = {32'h999, 32'h08000000};
            @(negedge clk);
        end
        IF_over = 1'b0;
        check_eq("stall_inst_kept", 149'(ID_inst), 149'(32'hAC220008));
        ID_allow = 1'b1;
        #1;
        pulse_check("stall");
        @(negedge clk);
        check_eq("stall_no_restart", 149'(ID_over), 149'(0));
        check_eq("stall_pc_kept", 149'(ID_pc), 149'(32'h400));

        // ADDU $3, $1, $2 with a second IF_over during READ
        @(negedge clk);
        IF_over   = 1'b1;
        IF_ID_bus = {32'h300, 32'h00221821};
        rs_value  = 32'd10;
        rt_value  = 32'd20;
        @(negedge clk);
        IF_ID_bus = {32'h999, 32'h3C01FFFF};
        @(negedge clk);
        IF_over = 1'b0;
        check_eq("ign_pc", 149'(ID_pc), 149'(32'h300));
        check_eq("ign_inst", 149'(ID_inst), 149'(32'h00221821));
        check_eq("ign_bus", ID_EXE_bus,
                 {OpAdd, 32'd10, 32'd20, 4'b0000, 32'd20, 5'd3, 32'h300});
        pulse_check("ign");

        // Reset during READ aborts the instruction
        @(negedge clk);
        IF_over   = 1'b1;
        IF_ID_bus = {32'h200, 32'h1022FFFF};
        rs_value  = 32'd3;
        rt_value  = 32'd3;
        @(negedge clk);
        IF_over = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("rr_jbr", 149'(jbr_bus), 149'(0));
        check_eq("rr_exe", ID_EXE_bus, 149'(0));
        check_eq("rr_inst", 149'(ID_inst), 149'(0));
        check_eq("rr_pc", 149'(ID_pc), 149'(0));
        for (int i = 0; i < 3; i++) begin
            check_eq("rr_no_over", 149'(ID_over), 149'(0));
            @(negedge clk);
        end

        // Illegal opcode 0x3F completes as NOP
        send(32'h500, 32'hFC221234, 32'd1, 32'd2);
        check_eq("ill_aluop", 149'(ID_EXE_bus[148:137]), 149'(0));
        check_eq("ill_wdest", 149'(ID_EXE_bus[36:32]), 149'(0));
        check_eq("ill_mem", 149'(ID_EXE_bus[72:69]), 149'(0));
        check_eq("ill_jbr", 149'(jbr_bus), 149'(0));
        pulse_check("ill");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
